// File: rtl/regfile_pkg.sv
// Shared constants and the write-port priority resolver for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_D = 32;
  localparam int NREGS_D = 32;
  localparam int MAX_WR = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] port;
  } wr_sel_t;

  // hits[j] = port j is enabled and targets the address of interest; highest index wins.
  function automatic wr_sel_t wr_winner(input logic [MAX_WR-1:0] hits);
    wr_sel_t sel;
    sel = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (hits[j]) begin
        sel.valid = 1'b1;
        sel.port  = 2'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_read_lane.sv
// One registered read lane: latched address, output register and the stall/bypass/zero mux.
module regfile_read_lane
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_stall,
  input  logic [AW-1:0]     i_rd_adrs,
  input  logic [XLEN-1:0]   i_word,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_adrs,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic [AW-1:0]     o_sel_adrs,
  output logic [XLEN-1:0]   o_rd_data
);

  logic [AW-1:0]     r_adrs;
  logic [XLEN-1:0]   r_data;
  logic [AW-1:0]     w_adrs;
  logic [MAX_WR-1:0] w_hits;
  wr_sel_t           w_sel;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_next;

  // While stalled the lane keeps looking at the register it latched earlier.
  assign w_adrs     = i_stall ? r_adrs : i_rd_adrs;
  assign o_sel_adrs = w_adrs;
  assign o_rd_data  = r_data;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_hits  = '0;
    w_wdata = '0;
    for (int j = 0; j < NWR; j++) begin
      w_hits[j] = i_wr_en[j] && (i_wr_adrs[j*AW +: AW] == w_adrs);
    end
    w_sel = wr_winner(w_hits);
    for (int j = 0; j < NWR; j++) begin
      if (w_sel.port == 2'(j)) w_wdata = i_wr_data[j*XLEN +: XLEN];
    end
  end

  always_comb begin
    w_next = r_data;
    if (ZERO_REG != 0 && w_adrs == '0) begin
      w_next = '0;
    end else if (i_stall) begin
      // A held lane still follows writes to its register so it is never stale on release.
      if (w_sel.valid) w_next = w_wdata;
    end else if (BYPASS != 0 && w_sel.valid) begin
      w_next = w_wdata;
    end else begin
      w_next = i_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_adrs <= '0;
      r_data <= '0;
    end else begin
      if (!i_stall) r_adrs <= i_rd_adrs;
      r_data <= w_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file: storage array, write ports and NRD read lanes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int NREGS    = NREGS_D,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic [NRD*AW-1:0]   RD_ADRS,
  output logic [NRD*XLEN-1:0] RD_DATA,
  input  logic [NWR-1:0]      WR_EN,
  input  logic [NWR*AW-1:0]   WR_ADRS,
  input  logic [NWR*XLEN-1:0] WR_DATA
);

  logic [XLEN-1:0] r_regs [NREGS];

  // NOTE: the array is cleared by the asynchronous reset, so it is built from flops, not a RAM macro.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      // Ascending port order: the last assignment, i.e. the highest enabled port, wins.
      for (int j = 0; j < NWR; j++) begin
        if (WR_EN[j] && !(ZERO_REG != 0 && WR_ADRS[j*AW +: AW] == '0)) begin
          r_regs[WR_ADRS[j*AW +: AW]] <= WR_DATA[j*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_lane
    logic [AW-1:0]   w_sel_adrs;
    logic [XLEN-1:0] w_word;

    assign w_word = r_regs[w_sel_adrs];

    regfile_read_lane #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_lane (
      .CLK        (CLK),
      .RESET      (RESET),
      .i_stall    (STALL),
      .i_rd_adrs  (RD_ADRS[k*AW +: AW]),
      .i_word     (w_word),
      .i_wr_en    (WR_EN),
      .i_wr_adrs  (WR_ADRS),
      .i_wr_data  (WR_DATA),
      .o_sel_adrs (w_sel_adrs),
      .o_rd_data  (RD_DATA[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench: two register files (bypass on / off) share one stimulus stream.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          STALL;
  logic [2*AW-1:0]   RD_ADRS;
  logic [2*XLEN-1:0] RD_DATA;
  logic [2*XLEN-1:0] rd_data_nb;
  logic [1:0]        WR_EN;
  logic [2*AW-1:0]   WR_ADRS;
  logic [2*XLEN-1:0] WR_DATA;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          which;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  regfile_mp #(.NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .RD_ADRS(RD_ADRS), .RD_DATA(RD_DATA),
    .WR_EN(WR_EN), .WR_ADRS(WR_ADRS), .WR_DATA(WR_DATA)
  );

  regfile_mp #(.NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .RD_ADRS(RD_ADRS), .RD_DATA(rd_data_nb),
    .WR_EN(WR_EN), .WR_ADRS(WR_ADRS), .WR_DATA(WR_DATA)
  );

  always #5 CLK = ~CLK;

  // which: 0/1 = bypass DUT lane 0/1, 2/3 = no-bypass DUT lane 0/1
  function automatic logic [31:0] observe(input int which);
    case (which)
      0:       return RD_DATA[0 +: XLEN];
      1:       return RD_DATA[XLEN +: XLEN];
      2:       return rd_data_nb[0 +: XLEN];
      default: return rd_data_nb[XLEN +: XLEN];
    endcase
  endfunction

  task automatic expect_val(input string tag, input int which, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.which = which; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [31:0] obs;
    obs = observe(e.which);
    total++;
    assert (obs === e.exp) else begin
      bad++;
      $error("FAIL %s (lane sel %0d): observed=%h expected=%h", e.tag, e.which, obs, e.exp);
    end
  endtask

  task automatic flush();
    while (sb.size() > 0) check(sb.pop_front());
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    flush();
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d);
    WR_EN[port]              = 1'b1;
    WR_ADRS[port*AW +: AW]   = a;
    WR_DATA[port*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int lane, input logic [AW-1:0] a);
    RD_ADRS[lane*AW +: AW] = a;
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; RD_ADRS = '0; WR_EN = '0; WR_ADRS = '0; WR_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    for (int w = 0; w < 4; w++) expect_val("reset_state", w, 32'h0);
    flush();
    RESET = 1'b0;

    // Write x5 and read it back, then an asynchronous reset between edges.
    wr(0, 5'd5, 32'hDEADBEEF);
    step();
    WR_EN = '0; rd(0, 5'd5);
    expect_val("x5_before_reset", 0, 32'hDEADBEEF);
    expect_val("x5_before_reset_nb", 2, 32'hDEADBEEF);
    step();
    #2 RESET = 1'b1;
    #1;
    for (int w = 0; w < 4; w++) expect_val("async_reset", w, 32'h0);
    flush();
    RESET = 1'b0;
    expect_val("x5_after_reset", 0, 32'h0);
    step();

    // Write then read on the following edge.
    wr(0, 5'd3, 32'h12345678); rd(0, 5'd0);
    step();
    WR_EN = '0; rd(0, 5'd3);
    expect_val("write_read", 0, 32'h12345678);
    expect_val("write_read_nb", 2, 32'h12345678);
    step();

    // Same-cycle bypass: bypass DUT forwards, the other sees the old contents.
    wr(0, 5'd7, 32'hA5A5A5A5); rd(0, 5'd7); rd(1, 5'd7);
    expect_val("bypass_l0", 0, 32'hA5A5A5A5);
    expect_val("bypass_l1", 1, 32'hA5A5A5A5);
    expect_val("no_bypass_l0", 2, 32'h0);
    expect_val("no_bypass_l1", 3, 32'h0);
    step();
    WR_EN = '0;
    expect_val("no_bypass_next", 2, 32'hA5A5A5A5);
    step();

    // Register 0 stays zero, even with a same-cycle write to it.
    wr(0, 5'd0, 32'hFFFFFFFF); rd(0, 5'd0); rd(1, 5'd0);
    for (int w = 0; w < 4; w++) expect_val("x0_same_cycle", w, 32'h0);
    step();
    WR_EN = '0;
    expect_val("x0_after_l0", 0, 32'h0);
    expect_val("x0_after_l1", 1, 32'h0);
    step();

    // Collision: port 1 beats port 0 for storage and bypass.
    wr(0, 5'd9, 32'h11); wr(1, 5'd9, 32'h22); rd(0, 5'd9);
    expect_val("collision_bypass", 0, 32'h22);
    expect_val("collision_nb_old", 2, 32'h0);
    step();
    WR_EN = '0; rd(1, 5'd9);
    expect_val("collision_stored", 1, 32'h22);
    expect_val("collision_stored_nb", 3, 32'h22);
    step();

    // Stall tracking.
    wr(0, 5'd4, 32'h1); wr(1, 5'd2, 32'h2222);
    step();
    wr(0, 5'd8, 32'h88); WR_EN[1] = 1'b0;
    step();
    WR_EN = '0; rd(0, 5'd4); rd(1, 5'd2);
    expect_val("pre_stall_l0", 0, 32'h1);
    expect_val("pre_stall_l1", 1, 32'h2222);
    step();
    STALL = 1'b1; rd(0, 5'd8); wr(0, 5'd4, 32'h99);
    expect_val("stall_track_l0", 0, 32'h99);
    expect_val("stall_track_l0_nb", 2, 32'h99);
    expect_val("stall_hold_l1", 1, 32'h2222);
    step();
    WR_EN = '0; wr(1, 5'd2, 32'h3333); WR_EN[1] = 1'b0;
    expect_val("stall_hold_l0", 0, 32'h99);
    step();
    STALL = 1'b0;
    expect_val("stall_release_l0", 0, 32'h88);
    expect_val("stall_release_l1", 1, 32'h2222);
    step();

    // Reset asserted in the middle of a stall.
    STALL = 1'b1;
    #2 RESET = 1'b1;
    #1;
    for (int w = 0; w < 4; w++) expect_val("reset_mid_stall", w, 32'h0);
    flush();
    RESET = 1'b0;
    wr(0, 5'd0, 32'h5555);
    expect_val("stall_latched_zero", 0, 32'h0);
    step();
    STALL = 1'b0; WR_EN = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
